// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared exception codes, control-bit positions and reset defaults for pipeline stage registers
package pipe_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int CTRL_REGWRITE_BIT = 0;
  localparam int CTRL_MEMWRITE_BIT = 1;

  // A faulting instruction must never commit a register or memory write.
  localparam logic [7:0]  DEF_KILL_MASK = 8'h03;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - saturating event counter with enable and synchronous active-low reset
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid, stall, flush bubble and exception merge
// Optional stall/flush counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = 96,
  parameter int                 CTRL_W    = 8,
  parameter int                 EXC_W     = 5,
  parameter logic [CTRL_W-1:0]  KILL_MASK = CTRL_W'(DEF_KILL_MASK),
  parameter logic [31:0]        RESET_PC  = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  stage_exc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              out_has_exc
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [EXC_W-1:0] merged_exc;

  // The oldest exception wins: one carried from an earlier stage beats a new one.
  assign merged_exc = (in_exc != '0) ? in_exc : stage_exc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_bd    <= 1'b0;
      out_exc   <= '0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      // The bubble keeps PC/BD so an interrupt taken on it still reports a correct EPC.
      out_valid <= 1'b0;
      out_pc    <= in_pc;
      out_bd    <= in_bd;
      out_exc   <= '0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      out_bd    <= in_bd;
      out_exc   <= in_valid ? merged_exc : '0;
      out_ctrl  <= (merged_exc != '0) ? (in_ctrl & ~KILL_MASK) : in_ctrl;
      out_data  <= in_data;
    end
  end

  assign out_has_exc = (out_exc != '0) && out_valid;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_win;
  logic flush_win;

  assign flush_win = flush;
  assign stall_win = stall && !flush;

  pipe_perf_cnt #(.W(32)) u_stall_cnt (
    .clk    (clk),
    .resetn (reset),
    .en     (stall_win),
    .count  (stall_cnt)
  );

  pipe_perf_cnt #(.W(32)) u_flush_cnt (
    .clk    (clk),
    .resetn (reset),
    .en     (flush_win),
    .count  (flush_cnt)
  );
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core.
- One instance replaces each hand-written D/E/M/W register.
- Adds to the current register:
  - valid bit
  - stall/hold
  - flush with EPC-preserving bubble
  - precise-exception merge with side-effect masking
- Sits between any two stages and is driven by the hazard unit and the CP0 flush logic.

Parameters:
- DATA_W, 96: width of the opaque datapath payload (ALU results, store data, register addresses packed by the instantiating stage).
- CTRL_W, 8: width of the control-signal vector.
- EXC_W, 5: width of the exception code; 0 means no exception.
- KILL_MASK, 8'h03: control bits forced to 0 when the latched exception code is non-zero. Bit0 = RegWrite, bit1 = MemWrite.
- RESET_PC, 32'h0000_3000: PC value loaded on reset.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- stall, input, 1: hold the current contents.
- flush, input, 1: insert a bubble.
- in_valid, input, 1: upstream instruction valid.
- in_pc, input, 32: upstream PC.
- in_bd, input, 1: upstream branch-delay-slot flag.
- in_exc, input, EXC_W: exception carried from earlier stages.
- stage_exc, input, EXC_W: exception detected in the upstream stage this cycle.
- in_ctrl, input, CTRL_W: control vector.
- in_data, input, DATA_W: payload.
- out_valid, output, 1: registered valid.
- out_pc, output, 32: registered PC.
- out_bd, output, 1: registered branch-delay-slot flag.
- out_exc, output, EXC_W: registered merged exception code.
- out_ctrl, output, CTRL_W: registered control vector, masked.
- out_data, output, DATA_W: registered payload.
- out_has_exc, output, 1: combinational `(out_exc != 0) && out_valid`.

Behaviour:
- All outputs are registered; latency is one cycle. out_has_exc is the only combinational output, decoded from registered state.
- Priority per rising edge: reset low > flush > stall > load.
- Reset (reset==0):
  - out_valid=0, out_pc=RESET_PC, out_bd=0, out_exc=0, out_ctrl=0, out_data=0.
  - A reset asserted mid-stall or mid-flush overrides both in the same cycle.
- Flush (flush==1, overrides stall):
  - out_valid=0, out_exc=0, out_ctrl=0, out_data=0.
  - out_pc<=in_pc and out_bd<=in_bd, so that a later interrupt on a bubble still reports a correct EPC/BD.
- Stall (stall==1, flush==0): every output holds its value, including out_pc and out_bd.
- Load (stall==0, flush==0): out_valid<=in_valid, out_pc<=in_pc, out_bd<=in_bd, out_data<=in_data.
- Exception merge on load:
  - merged = (in_exc != 0) ? in_exc : stage_exc. The earlier stage always wins.
  - out_exc <= in_valid ? merged : 0. An invalid slot never carries an exception.
- Control masking on load:
  - out_ctrl <= (merged != 0) ? (in_ctrl & ~KILL_MASK) : in_ctrl.
  - Net effect: a faulting instruction never writes the register file or memory downstream.
- Width rules: no arithmetic. EXC_W codes are compared against 0 only. KILL_MASK is CTRL_W wide.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds two output ports, stall_cnt[31:0] and flush_cnt[31:0].
  - Each is a saturating counter, incremented on every edge where the corresponding condition is the winning priority case.
  - Both hold at 32'hFFFF_FFFF rather than wrapping.
  - Both clear to 0 on reset.
- When undefined, the ports and counters do not exist; base behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - EXC_NONE=0, EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - CTRL_REGWRITE_BIT=0, CTRL_MEMWRITE_BIT=1.
  - Default KILL_MASK.
  - RESET_PC.
- One sub-module, pipe_perf_cnt: a single saturating counter with enable and active-low synchronous reset, instantiated twice under the macro.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_pc=32'h3004 -> out_valid=0, out_pc=32'h3000, out_ctrl=0, out_exc=0.
- Load: in_valid=1, in_pc=32'h3008, in_ctrl=8'h03, in_data=96'hA5 -> next cycle outputs equal the inputs, out_has_exc=0.
- Stall: stall=1 for 3 cycles while inputs change to in_pc=32'h300C -> out_pc stays 32'h3008 and all outputs are unchanged. With PIPE_STAGE_PERF_EN, stall_cnt=3.
- Flush+stall together: flush=1, stall=1, in_pc=32'h3010, in_bd=1 -> out_valid=0, out_ctrl=0, out_pc=32'h3010, out_bd=1.
- Exception priority: in_exc=EXC_ADEL, stage_exc=EXC_OV, in_ctrl=8'h03 -> out_exc=4, out_ctrl=8'h00, out_has_exc=1.
- Invalid slot: in_exc=0, stage_exc=EXC_RI, in_valid=0 -> out_exc=0, out_has_exc=0. Then in_valid=1 with the same inputs -> out_exc=10 and RegWrite masked.
